// File: rtl/data_mem_responder_pkg.sv
// rtl/data_mem_responder_pkg.sv - shared load/store types and the alignment rule
package data_mem_responder_pkg;

    typedef enum logic {
        MEM_READ  = 1'b0,
        MEM_WRITE = 1'b1
    } mem_dir_e;

    typedef enum logic [2:0] {
        SIZE_B  = 3'b000,
        SIZE_H  = 3'b001,
        SIZE_W  = 3'b010,
        SIZE_BU = 3'b100,
        SIZE_HU = 3'b101
    } mem_size_e;

    typedef enum logic [1:0] {
        RSP_IDLE,
        RSP_ACCESS,
        RSP_RESP
    } mem_rsp_state_e;

    // Shared with the load/store unit so both sides agree on what is misaligned.
    function automatic logic mem_misaligned(input mem_size_e size, input logic [1:0] addr_lo);
        case (size)
            SIZE_H, SIZE_HU: return addr_lo[0];
            SIZE_W:          return addr_lo != 2'b00;
            default:         return 1'b0;
        endcase
    endfunction

    function automatic logic mem_size_illegal(input logic [2:0] code);
        return (code == 3'b011) || (code == 3'b110) || (code == 3'b111);
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - request/response handshake bundle for the data memory
interface data_mem_responder_if;
    import data_mem_responder_pkg::*;

    logic        req_valid;
    logic        req_ready;
    mem_dir_e    req_dir;
    mem_size_e   req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_dir, req_size, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_dir, req_size, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/data_mem_responder_lane_steer.sv
// rtl/data_mem_responder_lane_steer.sv - byte-lane enables, store replication and load extension
module mem_lane_steer
    import data_mem_responder_pkg::*;
(
    input  mem_size_e   i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_illegal
);

    logic [31:0] w_shifted;
    logic [2:0]  w_code;

    assign w_shifted = i_rword >> {i_addr_lo, 3'b000};
    assign w_code    = i_size;
    assign o_illegal = mem_misaligned(i_size, i_addr_lo) | mem_size_illegal(w_code);

    always_comb begin
        o_be    = 4'b0000;
        o_wdata = i_wdata;
        o_rdata = 32'h0;
        case (i_size)
            SIZE_B: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{w_shifted[7]}}, w_shifted[7:0]};
            end
            SIZE_BU: o_rdata = {24'h0, w_shifted[7:0]};
            SIZE_H: begin
                o_be    = 4'b0011 << i_addr_lo;
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = {{16{w_shifted[15]}}, w_shifted[15:0]};
            end
            SIZE_HU: o_rdata = {16'h0, w_shifted[15:0]};
            SIZE_W: begin
                o_be    = 4'b1111;
                o_rdata = w_shifted;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - serialised data-memory endpoint: FSM, latency counter, RAM
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int LATENCY = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    data_mem_responder_if.slave  bus
);

    localparam int         DEPTH    = 2 ** (ADDR_W - 2);
    localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

    mem_rsp_state_e r_state;
    mem_rsp_state_e w_state_next;

    logic [2:0]        r_cnt;
    mem_dir_e          r_dir;
    mem_size_e         r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic              r_err;
    logic [31:0]       r_mem [DEPTH];

    logic        w_accept;
    logic        w_commit;
    logic        w_err;
    logic [3:0]  w_be;
    logic [31:0] w_wdata_rep;
    logic [31:0] w_rdata_ext;
    logic [31:0] w_rword;
    logic        w_illegal;
    logic        w_unused_addr;

    assign w_unused_addr = ^bus.req_addr[31:ADDR_W];
    assign w_accept      = bus.req_valid && bus.req_ready;
    assign w_commit      = (r_state == RSP_ACCESS) && (r_cnt == 3'd0);
    assign w_rword       = r_mem[r_addr[ADDR_W-1:2]];

    mem_lane_steer u_steer (
        .i_size    (r_size),
        .i_addr_lo (r_addr[1:0]),
        .i_wdata   (r_wdata),
        .i_rword   (w_rword),
        .o_be      (w_be),
        .o_wdata   (w_wdata_rep),
        .o_rdata   (w_rdata_ext),
        .o_illegal (w_illegal)
    );

    // Unsigned sizes only make sense for loads.
    assign w_err = w_illegal ||
                   ((r_dir == MEM_WRITE) && ((r_size == SIZE_BU) || (r_size == SIZE_HU)));

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= RSP_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RSP_IDLE:   if (bus.req_valid)  w_state_next = RSP_ACCESS;
            RSP_ACCESS: if (r_cnt == 3'd0)  w_state_next = RSP_RESP;
            RSP_RESP:   if (bus.rsp_ready)  w_state_next = RSP_IDLE;
            default:                        w_state_next = RSP_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt   <= 3'd0;
            r_dir   <= MEM_READ;
            r_size  <= SIZE_B;
            r_addr  <= '0;
            r_wdata <= 32'h0;
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt   <= CNT_INIT;
                r_dir   <= bus.req_dir;
                r_size  <= bus.req_size;
                r_addr  <= bus.req_addr[ADDR_W-1:0];
                r_wdata <= bus.req_wdata;
            end else if ((r_state == RSP_ACCESS) && (r_cnt != 3'd0)) begin
                r_cnt <= r_cnt - 3'd1;
            end
            if (w_commit) begin
                r_rdata <= (w_err || (r_dir == MEM_WRITE)) ? 32'h0 : w_rdata_ext;
                r_err   <= w_err;
            end
        end
    end

    // RAM has no reset; a reset landing on the commit edge blocks the store.
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_commit && (r_dir == MEM_WRITE) && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[r_addr[ADDR_W-1:2]][8*i +: 8] <= w_wdata_rep[8*i +: 8];
            end
        end
    end

    assign bus.req_ready = (r_state == RSP_IDLE) && !i_rst;
    assign bus.rsp_valid = (r_state == RSP_RESP);
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - randomized and directed bench against a byte-array memory model
module tb_data_mem_responder;
    import data_mem_responder_pkg::*;

    typedef struct {
        mem_dir_e    d;
        mem_size_e   s;
        logic [31:0] a;
        logic [31:0] w;
        logic [31:0] rd;
        logic        er;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        tb_sel = 1'b0;
    logic        tb_req_valid = 1'b0;
    mem_dir_e    tb_dir = MEM_READ;
    mem_size_e   tb_size = SIZE_W;
    logic [31:0] tb_addr = 32'h0;
    logic [31:0] tb_wdata = 32'h0;
    logic        tb_rsp_ready = 1'b1;

    int checks = 0;
    int failures = 0;

    logic [7:0] mb [2][65536];
    bit         bv [2][65536];

    data_mem_responder_if if1 ();
    data_mem_responder_if if4 ();

    assign if1.req_valid = tb_req_valid & ~tb_sel;
    assign if4.req_valid = tb_req_valid & tb_sel;
    assign if1.req_dir   = tb_dir;
    assign if4.req_dir   = tb_dir;
    assign if1.req_size  = tb_size;
    assign if4.req_size  = tb_size;
    assign if1.req_addr  = tb_addr;
    assign if4.req_addr  = tb_addr;
    assign if1.req_wdata = tb_wdata;
    assign if4.req_wdata = tb_wdata;
    assign if1.rsp_ready = tb_rsp_ready;
    assign if4.rsp_ready = tb_rsp_ready;

    logic        w_req_ready, w_rsp_valid, w_rsp_err;
    logic [31:0] w_rsp_rdata;
    assign w_req_ready = tb_sel ? if4.req_ready : if1.req_ready;
    assign w_rsp_valid = tb_sel ? if4.rsp_valid : if1.rsp_valid;
    assign w_rsp_rdata = tb_sel ? if4.rsp_rdata : if1.rsp_rdata;
    assign w_rsp_err   = tb_sel ? if4.rsp_err   : if1.rsp_err;

    data_mem_responder #(.ADDR_W(16), .LATENCY(1)) dut1 (.i_clk(clk), .i_rst(rst), .bus(if1.slave));
    data_mem_responder #(.ADDR_W(16), .LATENCY(4)) dut4 (.i_clk(clk), .i_rst(rst), .bus(if4.slave));

    vec_t dir_vecs [15] = '{
        '{MEM_WRITE, SIZE_W,  32'h10, 32'hDEADBEEF, 32'h00000000, 1'b0},
        '{MEM_READ,  SIZE_W,  32'h10, 32'h0,        32'hDEADBEEF, 1'b0},
        '{MEM_READ,  SIZE_B,  32'h13, 32'h0,        32'hFFFFFFDE, 1'b0},
        '{MEM_READ,  SIZE_BU, 32'h13, 32'h0,        32'h000000DE, 1'b0},
        '{MEM_READ,  SIZE_H,  32'h12, 32'h0,        32'hFFFFDEAD, 1'b0},
        '{MEM_READ,  SIZE_HU, 32'h10, 32'h0,        32'h0000BEEF, 1'b0},
        '{MEM_WRITE, SIZE_B,  32'h11, 32'h55,       32'h00000000, 1'b0},
        '{MEM_READ,  SIZE_W,  32'h10, 32'h0,        32'hDEAD55EF, 1'b0},
        '{MEM_WRITE, SIZE_H,  32'h12, 32'h1234,     32'h00000000, 1'b0},
        '{MEM_READ,  SIZE_W,  32'h10, 32'h0,        32'h123455EF, 1'b0},
        '{MEM_WRITE, SIZE_W,  32'h12, 32'hFFFFFFFF, 32'h00000000, 1'b1},
        '{MEM_READ,  SIZE_W,  32'h10, 32'h0,        32'h123455EF, 1'b0},
        '{MEM_READ,  SIZE_H,  32'h11, 32'h0,        32'h00000000, 1'b1},
        '{MEM_WRITE, SIZE_BU, 32'h10, 32'h77,       32'h00000000, 1'b1},
        '{MEM_READ,  mem_size_e'(3'b011), 32'h10, 32'h0, 32'h00000000, 1'b1}
    };

    // Reference: byte-addressed memory, size in bytes, natural alignment rule.
    task automatic model_op(input bit s, input mem_dir_e d, input mem_size_e sz,
                            input logic [31:0] a, input logic [31:0] w,
                            output logic [31:0] ex, output logic ee, output bit known);
        int n;
        bit bad;
        int ad;
        logic [2:0] code;
        code = sz;
        ad = int'(a[15:0]);
        bad = 1'b0;
        n = 1;
        case (code)
            3'd0, 3'd4: n = 1;
            3'd1, 3'd5: n = 2;
            3'd2:       n = 4;
            default:    bad = 1'b1;
        endcase
        if (ad % n != 0) bad = 1'b1;
        if (d == MEM_WRITE && (code == 3'd4 || code == 3'd5)) bad = 1'b1;
        ex = 32'h0;
        ee = bad;
        known = 1'b1;
        if (!bad && d == MEM_WRITE) begin
            for (int i = 0; i < n; i++) begin
                mb[s][ad + i] = w[8*i +: 8];
                bv[s][ad + i] = 1'b1;
            end
        end else if (!bad) begin
            for (int i = 0; i < n; i++) begin
                if (!bv[s][ad + i]) known = 1'b0;
                ex = ex | (32'(mb[s][ad + i]) << (8 * i));
            end
            if (code == 3'd0 && ex[7])  ex = ex | 32'hFFFFFF00;
            if (code == 3'd1 && ex[15]) ex = ex | 32'hFFFF0000;
        end
    endtask

    task automatic do_req(input bit s, input mem_dir_e d, input mem_size_e sz,
                          input logic [31:0] a, input logic [31:0] w,
                          output logic [31:0] rd, output logic er, output int lat,
                          output logic rdy_rsp, output logic rdy_after);
        int n = 0;
        @(negedge clk);
        tb_sel = s; tb_dir = d; tb_size = sz; tb_addr = a; tb_wdata = w;
        tb_rsp_ready = 1'b1; tb_req_valid = 1'b1;
        while (!w_req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (w_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL accept_timeout: req_ready=%b required 1", w_req_ready);
        end
        @(posedge clk);
        #1 tb_req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (w_rsp_valid !== 1'b1 && lat < 30);
        rd = w_rsp_rdata;
        er = w_rsp_err;
        rdy_rsp = w_req_ready;
        @(posedge clk);
        @(negedge clk);
        rdy_after = w_req_ready;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (if1.req_ready !== 1'b0 || if4.req_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_req_ready: got %b/%b required 0/0", if1.req_ready, if4.req_ready);
        end
        checks++;
        if (if1.rsp_valid !== 1'b0 || if1.rsp_rdata !== 32'h0 || if1.rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_rsp: valid=%b rdata=%h err=%b required 0/0/0",
                     if1.rsp_valid, if1.rsp_rdata, if1.rsp_err);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (if1.req_ready !== 1'b1 || if4.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_ready: got %b/%b required 1/1", if1.req_ready, if4.req_ready);
        end
    endtask

    task automatic test_directed();
        logic [31:0] rd, ex;
        logic er, ee, r1, r2;
        bit kn;
        int lat;
        foreach (dir_vecs[i]) begin
            do_req(1'b0, dir_vecs[i].d, dir_vecs[i].s, dir_vecs[i].a, dir_vecs[i].w, rd, er, lat, r1, r2);
            model_op(1'b0, dir_vecs[i].d, dir_vecs[i].s, dir_vecs[i].a, dir_vecs[i].w, ex, ee, kn);
            checks++;
            if (rd !== dir_vecs[i].rd || er !== dir_vecs[i].er) begin
                failures++;
                $display("FAIL directed[%0d]: rdata=%h err=%b required %h/%b",
                         i, rd, er, dir_vecs[i].rd, dir_vecs[i].er);
            end
            checks++;
            if (lat != 2) begin
                failures++;
                $display("FAIL directed_latency[%0d]: %0d cycles required 2", i, lat);
            end
            checks++;
            if (r1 !== 1'b0 || r2 !== 1'b1) begin
                failures++;
                $display("FAIL directed_ready[%0d]: in_rsp=%b after=%b required 0/1", i, r1, r2);
            end
        end
    endtask

    task automatic test_random(input bit s);
        logic [31:0] rd, ex, a, w, hi;
        logic er, ee, r1, r2;
        bit kn;
        int lat;
        mem_dir_e d;
        mem_size_e sz;
        int exp_lat;
        exp_lat = s ? 5 : 2;
        for (int i = 0; i < 16; i++) begin
            a = 32'h100 + 32'(4 * i);
            w = $urandom;
            do_req(s, MEM_WRITE, SIZE_W, a, w, rd, er, lat, r1, r2);
            model_op(s, MEM_WRITE, SIZE_W, a, w, ex, ee, kn);
        end
        for (int i = 0; i < 40; i++) begin
            d  = mem_dir_e'($urandom_range(0, 1));
            sz = mem_size_e'($urandom_range(0, 7));
            hi = $urandom;
            a  = {hi[31:16], 16'h0100 + 16'($urandom_range(0, 63))};
            w  = $urandom;
            do_req(s, d, sz, a, w, rd, er, lat, r1, r2);
            model_op(s, d, sz, a, w, ex, ee, kn);
            if (kn) begin
                checks++;
                if (rd !== ex || er !== ee) begin
                    failures++;
                    $display("FAIL random[%0d/%0d] dir=%0d size=%0d addr=%h: rdata=%h err=%b required %h/%b",
                             s, i, d, sz, a, rd, er, ex, ee);
                end
            end
            checks++;
            if (lat != exp_lat) begin
                failures++;
                $display("FAIL random_latency[%0d/%0d]: %0d required %0d", s, i, lat, exp_lat);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd, ex;
        logic er, ee, r1, r2;
        bit kn;
        int lat;
        int n;
        do_req(1'b1, MEM_WRITE, SIZE_W, 32'h200, 32'h0BADF00D, rd, er, lat, r1, r2);
        model_op(1'b1, MEM_WRITE, SIZE_W, 32'h200, 32'h0BADF00D, ex, ee, kn);
        do_req(1'b1, MEM_WRITE, SIZE_W, 32'h240, 32'hCAFE1234, rd, er, lat, r1, r2);
        model_op(1'b1, MEM_WRITE, SIZE_W, 32'h240, 32'hCAFE1234, ex, ee, kn);
        @(negedge clk);
        tb_sel = 1'b1; tb_dir = MEM_READ; tb_size = SIZE_W; tb_addr = 32'h240;
        tb_rsp_ready = 1'b0; tb_req_valid = 1'b1;
        @(posedge clk);
        #1 tb_req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (w_rsp_valid !== 1'b1 && n < 30);
        checks++;
        if (n != 5) begin
            failures++;
            $display("FAIL bp_latency: %0d cycles required 5", n);
        end
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (w_rsp_valid !== 1'b1 || w_rsp_rdata !== 32'hCAFE1234 || w_rsp_err !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold[%0d]: valid=%b rdata=%h err=%b required 1/cafe1234/0",
                         k, w_rsp_valid, w_rsp_rdata, w_rsp_err);
            end
            checks++;
            if (w_req_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_req_ready[%0d]: %b required 0", k, w_req_ready);
            end
            if (k == 1) begin
                tb_dir = MEM_WRITE; tb_addr = 32'h200; tb_wdata = 32'hFFFFFFFF; tb_req_valid = 1'b1;
            end
            if (k == 3) tb_req_valid = 1'b0;
        end
        tb_rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (w_rsp_valid !== 1'b0 || w_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release: valid=%b ready=%b required 0/1", w_rsp_valid, w_req_ready);
        end
        do_req(1'b1, MEM_READ, SIZE_W, 32'h200, 32'h0, rd, er, lat, r1, r2);
        model_op(1'b1, MEM_READ, SIZE_W, 32'h200, 32'h0, ex, ee, kn);
        checks++;
        if (rd !== ex || er !== 1'b0) begin
            failures++;
            $display("FAIL bp_ignored_req: rdata=%h err=%b required %h/0", rd, er, ex);
        end
    endtask

    task automatic test_reset_commit();
        logic [31:0] rd, ex;
        logic er, ee, r1, r2;
        bit kn;
        int lat;
        do_req(1'b0, MEM_WRITE, SIZE_W, 32'h20, 32'h11111111, rd, er, lat, r1, r2);
        model_op(1'b0, MEM_WRITE, SIZE_W, 32'h20, 32'h11111111, ex, ee, kn);
        do_req(1'b0, MEM_READ, SIZE_W, 32'h20, 32'h0, rd, er, lat, r1, r2);
        checks++;
        if (rd !== 32'h11111111) begin
            failures++;
            $display("FAIL rc_preload: rdata=%h required 11111111", rd);
        end
        @(negedge clk);
        tb_sel = 1'b0; tb_dir = MEM_WRITE; tb_size = SIZE_W; tb_addr = 32'h20;
        tb_wdata = 32'hAAAAAAAA; tb_req_valid = 1'b1;
        @(posedge clk);
        #1 begin tb_req_valid = 1'b0; rst = 1'b1; end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (if1.rsp_valid !== 1'b0 || if1.rsp_rdata !== 32'h0 || if1.rsp_err !== 1'b0 || if1.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL rc_outputs: valid=%b rdata=%h err=%b ready=%b required 0/0/0/1",
                     if1.rsp_valid, if1.rsp_rdata, if1.rsp_err, if1.req_ready);
        end
        do_req(1'b0, MEM_READ, SIZE_W, 32'h20, 32'h0, rd, er, lat, r1, r2);
        checks++;
        if (rd !== 32'h11111111 || er !== 1'b0) begin
            failures++;
            $display("FAIL rc_write_suppressed: rdata=%h err=%b required 11111111/0", rd, er);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random(1'b0);
        test_random(1'b1);
        test_backpressure();
        test_reset_commit();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
